toggle_cover_detect: RTL and testbench

TOGGLE_COVER_DETECT -- requirements
Module: toggle_cover_detect

---
 rtl/toggle_cover_pkg.sv | 18 +
 rtl/toggle_bit_tracker.sv | 56 +++++
 rtl/toggle_cover_detect.sv | 108 ++++++++++
 tb/tb_toggle_cover_detect.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
// Shared types and sizing helpers for the toggle coverage detector.
package toggle_cover_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } tc_state_e;

  // Bits needed to hold a count from 0 to width inclusive, i.e. clog2(width+1).
  function automatic int cnt_width(input int width);
    int r;
    r = 0;
    while ((1 << r) <= width) r++;
    return r;
  endfunction

endpackage

// File: rtl/toggle_bit_tracker.sv
// Per-bit rise/fall history; flags the first cycle in which both edges have been seen.
module toggle_bit_tracker (
  input  logic gbl_clk,
  input  logic reset,
  input  logic capture_i,
  input  logic detect_i,
  input  logic clear_i,
  input  logic sig_i,
  output logic newly_o
);

  logic prev_q, prev_d;
  logic seen_rise_q, seen_rise_d;
  logic seen_fall_q, seen_fall_d;
  logic done_q, done_d;
  logic rise, fall;

  assign rise    = ~prev_q & sig_i;
  assign fall    = prev_q & ~sig_i;
  // The completing edge counts in the same cycle it is sampled.
  assign newly_o = detect_i & (seen_rise_q | rise) & (seen_fall_q | fall) & ~done_q;

  always_comb begin
    prev_d      = prev_q;
    seen_rise_d = seen_rise_q;
    seen_fall_d = seen_fall_q;
    done_d      = done_q;
    if (clear_i) begin
      seen_rise_d = 1'b0;
      seen_fall_d = 1'b0;
      done_d      = 1'b0;
    end else if (capture_i) begin
      prev_d = sig_i;
    end else if (detect_i) begin
      prev_d      = sig_i;
      seen_rise_d = seen_rise_q | rise;
      seen_fall_d = seen_fall_q | fall;
      done_d      = done_q | newly_o;
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      prev_q      <= 1'b0;
      seen_rise_q <= 1'b0;
      seen_fall_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      seen_rise_q <= seen_rise_d;
      seen_fall_q <= seen_fall_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: rtl/toggle_cover_detect.sv
// Toggle coverage detector: sequences sampling/clear, counts bits that have both risen and fallen.
module toggle_cover_detect
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic                                gbl_clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic [WIDTH-1:0]                    sig,
  input  logic                                clr_req,
  output logic                                clr_ack,
  output logic [WIDTH-1:0]                    valid,
  output logic [cnt_width(WIDTH)-1:0]         covered,
  output logic                                all_covered,
  output tc_state_e                           dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  // clr_req/clr_ack: clr_req is a level; every cycle it is sampled high the state moves to
  // CLEAR, and clr_ack is high for each cycle spent in CLEAR. Coverage reads zero from the
  // first CLEAR cycle onwards.

  tc_state_e         state_q, state_d;
  logic              capture, detect, clear;
  logic [WIDTH-1:0]  newly;
  logic [CW-1:0]     pop;
  logic [WIDTH-1:0]  valid_q, valid_d;
  logic [CW-1:0]     covered_q, covered_d;
  logic              all_covered_q, all_covered_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_bit_tracker u_trk (
      .gbl_clk   (gbl_clk),
      .reset     (reset),
      .capture_i (capture),
      .detect_i  (detect),
      .clear_i   (clear),
      .sig_i     (sig[i]),
      .newly_o   (newly[i])
    );
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    detect  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      INIT: begin
        if (en) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) detect = 1'b1;
        else    state_d = INIT;
      end
      CLEAR: begin
        clear   = 1'b1;
        state_d = INIT;
      end
      default: state_d = INIT;
    endcase
    // A clear request wins over any capture or completion in the same cycle.
    if (clr_req) begin
      capture = 1'b0;
      detect  = 1'b0;
      clear   = 1'b1;
      state_d = CLEAR;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + CW'(newly[i]);
  end

  always_comb begin
    valid_d       = newly;
    covered_d     = clear ? '0 : covered_q + pop;
    all_covered_d = (covered_d == FULL);
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state_q       <= INIT;
      valid_q       <= '0;
      covered_q     <= '0;
      all_covered_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      covered_q     <= covered_d;
      all_covered_q <= all_covered_d;
    end
  end

  assign valid       = valid_q;
  assign covered     = covered_q;
  assign all_covered = all_covered_q;
  assign clr_ack     = (state_q == CLEAR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Bench for toggle_cover_detect: directed scenarios plus random traffic against a bit-history model.
module tb_toggle_cover_detect;
  import toggle_cover_pkg::*;

  localparam int W  = 27;
  localparam int CW = 5;
  localparam int EW = W + CW + 2;

  logic                 gbl_clk;
  logic                 reset;
  logic                 en;
  logic [W-1:0]         sig;
  logic                 clr_req;
  logic                 clr_ack;
  logic [W-1:0]         valid;
  logic [CW-1:0]        covered;
  logic                 all_covered;
  tc_state_e            dbg_state;

  toggle_cover_detect #(.WIDTH(W)) dut (
    .gbl_clk     (gbl_clk),
    .reset       (reset),
    .en          (en),
    .sig         (sig),
    .clr_req     (clr_req),
    .clr_ack     (clr_ack),
    .valid       (valid),
    .covered     (covered),
    .all_covered (all_covered),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    gbl_clk = 1'b0;
    forever #5 gbl_clk = ~gbl_clk;
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  // reference model: history of each bit since the last clear
  bit         m_armed;     // a baseline sample exists to compare against
  bit         m_clearing;  // the cycle spent in the clear state
  bit [W-1:0] m_prev, m_sr, m_sf, m_done;
  int         m_cov;

  task automatic step(input bit rst_n, input bit e, input logic [W-1:0] s, input bit c);
    logic [W-1:0] exp_v;
    bit           exp_ack;
    @(negedge gbl_clk);
    reset   = rst_n;
    en      = e;
    sig     = s;
    clr_req = c;
    exp_v   = '0;
    exp_ack = 1'b0;
    if (!rst_n) begin
      m_armed = 0; m_clearing = 0; m_prev = '0; m_sr = '0; m_sf = '0; m_done = '0; m_cov = 0;
    end else if (c) begin
      m_sr = '0; m_sf = '0; m_done = '0; m_cov = 0;
      m_armed = 0; m_clearing = 1; exp_ack = 1'b1;
    end else if (m_clearing) begin
      m_clearing = 0;
    end else if (!e) begin
      m_armed = 0;
    end else if (!m_armed) begin
      m_prev  = s;
      m_armed = 1;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!m_prev[i] && s[i]) m_sr[i] = 1'b1;
        if (m_prev[i] && !s[i]) m_sf[i] = 1'b1;
        if (m_sr[i] && m_sf[i] && !m_done[i]) begin
          m_done[i] = 1'b1;
          exp_v[i]  = 1'b1;
          m_cov++;
        end
      end
      m_prev = s;
    end
    exp_q.push_back({exp_v, CW'(m_cov), (m_cov == W), exp_ack});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, '1, 1'b1);
  endtask

  // monitor: one expected word per clock edge
  initial begin
    logic [EW-1:0] e, got;
    forever begin
      @(posedge gbl_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {valid, covered, all_covered, clr_ack};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL out#%0d got valid=%h cov=%0d all=%b ack=%b, expected valid=%h cov=%0d all=%b ack=%b",
                   n_vec, got[EW-1 -: W], got[CW+1:2], got[1], got[0],
                   e[EW-1 -: W], e[CW+1:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] b3, b5, b7, cur, mask;
    n_vec = 0; n_err = 0;
    reset = 1'b0; en = 1'b0; sig = '0; clr_req = 1'b0;
    b3 = W'(1) << 3; b5 = W'(1) << 5; b7 = W'(1) << 7;

    // single bit full toggle, then repeat toggles give nothing new
    do_reset();
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);
    step(1, 1, b3, 0);
    step(1, 1, b3, 0);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);
    step(1, 1, b3, 0);
    step(1, 1, '0, 0);
    step(1, 1, b3, 0);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);

    // every bit at once
    do_reset();
    step(1, 1, '0, 0);
    step(1, 1, '1, 0);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);
    step(1, 1, '1, 0);

    // high at the first sample is a baseline, not a rise
    do_reset();
    repeat (4) step(1, 1, '1, 0);

    // clear in the completing cycle, then toggle again
    do_reset();
    step(1, 1, '0, 0);
    step(1, 1, b5, 0);
    step(1, 1, '0, 1);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);
    step(1, 1, b5, 0);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);

    // held clear re-acknowledges
    step(1, 1, '0, 1);
    step(1, 1, '0, 1);
    step(1, 1, '0, 0);

    // rise hidden by en=0 is not seen
    do_reset();
    step(1, 1, '0, 0);
    step(1, 0, b7, 0);
    step(1, 1, b7, 0);
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);

    // random traffic
    do_reset();
    cur = '0;
    for (int n = 0; n < 400; n++) begin
      mask = W'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 29) == 0) cur = ($urandom_range(0, 1) == 1) ? '1 : '0;
      else cur = cur ^ mask;
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), cur,
           ($urandom_range(0, 59) == 0));
    end

    repeat (3) @(negedge gbl_clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
